// File: rtl/id_imm_stage.sv
// Decodes RISC-V OP-IMM into registered ALU operands, with optional EX/MEM forwarding of rs1.
// One-cycle load latency; a valid output holds while out_ready_i is low, and a new instruction loads in the same cycle it drains.
module id_imm_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int FWD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic [31:0]        inst_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic               reg1_re_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic               ex_we_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               mem_we_i,
    input  logic [RADDR_W-1:0] mem_waddr_i,
    input  logic [XLEN-1:0]    mem_wdata_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [3:0]         alu_op_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               illegal_o,
    output logic [31:0]        dec_cnt_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SLT = 4'd1, ALU_SLTU = 4'd2,
        ALU_XOR  = 4'd3, ALU_OR  = 4'd4, ALU_AND  = 4'd5,
        ALU_SLL  = 4'd6, ALU_SRL = 4'd7, ALU_SRA  = 4'd8
    } alu_op_e;

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic               out_valid_q;
    logic [XLEN-1:0]    op1_q, op2_q;
    logic [3:0]         alu_op_q;
    logic               reg_we_q;
    logic [RADDR_W-1:0] reg_waddr_q;
    logic               illegal_q;
    logic [31:0]        dec_cnt_q;

    logic               legal;
    logic               is_shift;
    alu_op_e            alu_sel;
    logic [RADDR_W-1:0] rs1, rd;
    logic [XLEN-1:0]    imm_sext, shamt_zext, rs1_val;
    logic [XLEN-1:0]    op1_d, op2_d;
    logic [3:0]         alu_op_d;
    logic [RADDR_W-1:0] reg_waddr_d;
    logic               shamt_ok;
    logic               load;

    assign rs1        = RADDR_W'(inst_i[19:15]);
    assign rd         = RADDR_W'(inst_i[11:7]);
    assign imm_sext   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign shamt_zext = {{(XLEN-SHW){1'b0}}, inst_i[19+SHW:20]};
    // On RV32 a set bit 25 would mean a 6-bit shamt, which is reserved.
    assign shamt_ok   = (XLEN == 64) || !inst_i[25];

    always_comb begin
        legal    = 1'b0;
        is_shift = 1'b0;
        alu_sel  = ALU_ADD;
        if (inst_i[6:0] == 7'b0010011) begin
            case (inst_i[14:12])
                3'b000: begin legal = 1'b1; alu_sel = ALU_ADD;  end
                3'b010: begin legal = 1'b1; alu_sel = ALU_SLT;  end
                3'b011: begin legal = 1'b1; alu_sel = ALU_SLTU; end
                3'b100: begin legal = 1'b1; alu_sel = ALU_XOR;  end
                3'b110: begin legal = 1'b1; alu_sel = ALU_OR;   end
                3'b111: begin legal = 1'b1; alu_sel = ALU_AND;  end
                3'b001: begin
                    is_shift = 1'b1;
                    alu_sel  = ALU_SLL;
                    legal    = (inst_i[31:26] == 6'b000000) && shamt_ok;
                end
                default: begin
                    is_shift = 1'b1;
                    if (inst_i[31:26] == 6'b010000) begin
                        alu_sel = ALU_SRA;
                        legal   = shamt_ok;
                    end else begin
                        alu_sel = ALU_SRL;
                        legal   = (inst_i[31:26] == 6'b000000) && shamt_ok;
                    end
                end
            endcase
        end
    end

    // EX is younger than MEM, so it wins when both target rs1.
    always_comb begin
        rs1_val = reg1_rdata_i;
        if (rs1 == '0)
            rs1_val = '0;
        else if ((FWD_EN != 0) && ex_we_i && (ex_waddr_i == rs1))
            rs1_val = ex_wdata_i;
        else if ((FWD_EN != 0) && mem_we_i && (mem_waddr_i == rs1))
            rs1_val = mem_wdata_i;
    end

    assign op1_d       = legal ? rs1_val : '0;
    assign op2_d       = !legal ? '0 : (is_shift ? shamt_zext : imm_sext);
    assign alu_op_d    = legal ? alu_sel : ALU_ADD;
    assign reg_waddr_d = legal ? rd : '0;

    assign reg1_raddr_o = legal ? rs1 : '0;
    assign reg1_re_o    = legal && inst_valid_i;
    assign inst_ready_o = !out_valid_q || out_ready_i;
    assign load         = inst_valid_i && inst_ready_o && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_op_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            illegal_q   <= 1'b0;
            dec_cnt_q   <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_op_q    <= alu_op_d;
            reg_we_q    <= legal;
            reg_waddr_q <= reg_waddr_d;
            illegal_q   <= !legal;
            if (legal)
                dec_cnt_q <= dec_cnt_q + 32'd1;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign alu_op_o    = alu_op_q;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign illegal_o   = illegal_q;
    assign dec_cnt_o   = dec_cnt_q;

endmodule

// File: doc/id_imm_stage.md
ID_IMM_STAGE -- requirements
Module: id_imm_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RADDR_W, default 5, register address width.
REQ-003 Parameter FWD_EN, default 1, enables EX/MEM operand forwarding when 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 inst_valid_i  in  1  upstream instruction valid.
REQ-007 inst_ready_o  out  1  stage can accept an instruction this cycle.
REQ-008 inst_i  in  32  instruction word.
REQ-009 reg1_raddr_o / reg1_re_o  out  RADDR_W / 1  regfile read port 1 address and enable (combinational).
REQ-010 reg1_rdata_i  in  XLEN  regfile read data, same cycle.
REQ-011 ex_we_i, ex_waddr_i, ex_wdata_i  in  1/RADDR_W/XLEN  EX-stage pending write.
REQ-012 mem_we_i, mem_waddr_i, mem_wdata_i  in  1/RADDR_W/XLEN  MEM-stage pending write.
REQ-013 flush_i  in  1  discard the registered output.
REQ-014 out_valid_o / out_ready_i  out / in  1 / 1  downstream handshake.
REQ-015 op1_o, op2_o  out  XLEN  registered ALU operands.
REQ-016 alu_op_o  out  4  registered op: 0 ADD, 1 SLT, 2 SLTU, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA.
REQ-017 reg_we_o / reg_waddr_o  out  1 / RADDR_W  registered writeback enable and address.
REQ-018 illegal_o  out  1  registered: held instruction is not a legal OP-IMM.
REQ-019 dec_cnt_o  out  32  count of legal instructions accepted.

Function
REQ-020 Decode SHALL accept opcode 7'b0010011 with funct3 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI mapped to REQ-016 codes.
REQ-021 Non-shift op2 SHALL be inst_i[31:20] sign-extended to XLEN.
REQ-022 Shift op2 SHALL be shamt zero-extended: inst_i[24:20] when XLEN=32, inst_i[25:20] when XLEN=64.
REQ-023 Shift legality: inst_i[31:26] SHALL be 0 (SLLI/SRLI) or 6'b010000 (SRAI); XLEN=32 additionally requires inst_i[25]=0.
REQ-024 Illegal decode: alu_op 0, reg_we 0, reg_waddr 0, op1 0, op2 0, illegal 1, reg1_re 0, reg1_raddr 0.
REQ-025 Legal decode: reg1_raddr_o = inst_i[19:15], reg1_re_o = 1 while inst_valid_i; reg_we = 1, reg_waddr = inst_i[11:7].
REQ-026 op1 source priority (FWD_EN=1): rs1==0 -> 0; EX match (ex_we_i, ex_waddr_i==rs1) -> ex_wdata_i; MEM match -> mem_wdata_i; else reg1_rdata_i.
REQ-027 FWD_EN=0: op1 = 0 if rs1==0 else reg1_rdata_i; forwarding inputs ignored.
REQ-028 inst_ready_o SHALL equal !out_valid_o || out_ready_i (combinational, no bubble).
REQ-029 Load: when inst_valid_i && inst_ready_o && !flush_i, all output registers capture decode and out_valid_o=1 next cycle.
REQ-030 Drain: out_ready_i && out_valid_o with no load -> out_valid_o=0 next cycle; payload registers hold.
REQ-031 Stall: out_valid_o && !out_ready_i -> all output registers hold; inst_i not accepted.
REQ-032 flush_i SHALL dominate: out_valid_o=0 next cycle, no load, dec_cnt_o unchanged, even if inst_valid_i=1.
REQ-033 Load latency: exactly one cycle from accepting edge to out_valid_o.
REQ-034 dec_cnt_o SHALL increment by 1 on each load of a legal instruction, wrapping 0xFFFFFFFF -> 0.
REQ-035 Illegal instructions SHALL still load (out_valid_o=1, illegal_o=1) so downstream raises the exception.

Reset
REQ-036 While rst=1 at a clock edge: out_valid_o 0, op1_o 0, op2_o 0, alu_op_o 0, reg_we_o 0, reg_waddr_o 0, illegal_o 0, dec_cnt_o 0.
REQ-037 rst SHALL override load, flush and stall in the same cycle; an in-flight instruction is discarded.
REQ-038 First load possible on the first edge after rst deasserts.

Verification
REQ-039 ADDI x5,x1,-1 (0xFFF08293), x1=0x10, no forwarding -> next cycle op1 0x10, op2 0xFFFFFFFF, alu_op 0, reg_waddr 5, reg_we 1.
REQ-040 Same inst, ex_we=1 ex_waddr=1 ex_wdata=0xAA, mem_we=1 mem_waddr=1 mem_wdata=0xBB -> op1 0xAA; drop ex_we -> op1 0xBB; rs1=x0 with ex_waddr=0 -> op1 0.
REQ-041 SRAI x3,x4,7 -> alu_op 8, op2 7; XLEN=32 with inst[25]=1 -> illegal_o 1, reg_we 0, dec_cnt unchanged.
REQ-042 out_ready_i=0 for 3 cycles with inst_valid_i=1 -> inst_ready_o 0, outputs stable; ready=1 -> new inst loads same edge, out_valid_o stays 1.
REQ-043 flush_i=1 with inst_valid_i=1 -> out_valid_o 0 next cycle, dec_cnt unchanged; rst mid-stall -> all outputs zero.
